pwm_breath_seq: RTL and testbench

// - Breathing-LED sequencer around a period/duty PWM: owns the period counter and steps
//   the duty word up and down in a closed loop.
// - Sits between the LED driver pin and user start/stop controls.
// - Duty changes only on period boundaries, so the output never glitches mid-period.

---
 rtl/pwm_breath_seq.sv | 178 +++++++++++++++++
 tb/tb_pwm_breath_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breath_seq.sv
// Breathing-LED sequencer: a free-running period counter drives a PWM compare,
// and an FSM ramps the duty word up and down once per period.
// Build option: PWM_BREATH_REG_OUT_EN registers the pwm pin (one clk of added latency).
module pwm_breath_seq #(
    parameter logic [15:0] PERIOD       = 16'd25000,
    parameter logic [15:0] STEP         = 16'd250,
    parameter logic [15:0] HOLD_PERIODS = 16'd50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic        pwm,
    output logic [15:0] duty,
    output logic        busy,
    output logic        cycle_done
);

    localparam int unsigned DW = 16;
    localparam int unsigned SW = DW + 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_HOLD_HI   = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_HOLD_LO   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] hold_cnt_q, hold_cnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic          busy_q, busy_d;
    logic          cycle_done_c;

    logic          period_end;
    logic          hold_last;
    logic [SW-1:0] sum_up;
    logic [DW-1:0] duty_up;
    logic [DW-1:0] duty_dn;

    // Period boundary, hold exit and saturating duty arithmetic.
    always_comb begin
        period_end = (cnt_q == PERIOD - DW'(1));
        if (HOLD_PERIODS == DW'(0)) begin
            hold_last = 1'b1;
        end else begin
            hold_last = period_end && (hold_cnt_q == HOLD_PERIODS - DW'(1));
        end
        sum_up  = SW'(duty_q) + SW'(STEP);
        duty_up = (sum_up >= SW'(PERIOD)) ? PERIOD : sum_up[DW-1:0];
        duty_dn = (duty_q > STEP) ? (duty_q - STEP) : DW'(0);
    end

    // Next-state logic; duty and state both change on the period_end edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        duty_d       = duty_q;
        hold_cnt_d   = hold_cnt_q;
        stop_pend_d  = stop_pend_q;
        cycle_done_c = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = period_end ? DW'(0) : (cnt_q + DW'(1));
            if (stop) begin
                stop_pend_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d      = DW'(0);
                duty_d     = DW'(0);
                hold_cnt_d = DW'(0);
                if (start) begin
                    state_d     = ST_RAMP_UP;
                    stop_pend_d = stop;
                end
            end
            ST_RAMP_UP: begin
                if (period_end) begin
                    duty_d = duty_up;
                    if (duty_up == PERIOD) begin
                        state_d    = ST_HOLD_HI;
                        hold_cnt_d = DW'(0);
                    end
                end
            end
            ST_HOLD_HI: begin
                if (hold_last) begin
                    state_d    = ST_RAMP_DOWN;
                    hold_cnt_d = DW'(0);
                end else if (period_end) begin
                    hold_cnt_d = hold_cnt_q + DW'(1);
                end
            end
            ST_RAMP_DOWN: begin
                if (period_end) begin
                    duty_d = duty_dn;
                    if (duty_dn == DW'(0)) begin
                        state_d    = ST_HOLD_LO;
                        hold_cnt_d = DW'(0);
                    end
                end
            end
            ST_HOLD_LO: begin
                if (hold_last) begin
                    cycle_done_c = 1'b1;
                    hold_cnt_d   = DW'(0);
                    if (stop_pend_q) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                        cnt_d       = DW'(0);
                        duty_d      = DW'(0);
                    end else begin
                        state_d = ST_RAMP_UP;
                    end
                end else if (period_end) begin
                    hold_cnt_d = hold_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = DW'(0);
                duty_d      = DW'(0);
                hold_cnt_d  = DW'(0);
                stop_pend_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            duty_q      <= '0;
            hold_cnt_q  <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            hold_cnt_q  <= hold_cnt_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
        end
    end

`ifdef PWM_BREATH_REG_OUT_EN
    logic pwm_q, pwm_d;

    always_comb begin
        pwm_d = (cnt_q < duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;
`else
    // Compare straight off the counter/duty flops; reset clears both, so pwm falls with rst.
    assign pwm = (cnt_q < duty_q);
`endif

    assign duty       = duty_q;
    assign busy       = busy_q;
    assign cycle_done = cycle_done_c;

endmodule

// File: tb/tb_pwm_breath_seq.sv
// Directed bench for pwm_breath_seq with PERIOD=10, HOLD_PERIODS=2, STEP=5 and STEP=3.
module tb_pwm_breath_seq;

    logic        clk;
    logic        rst;
    logic        start, stop;
    logic        start3, stop3;
    logic        pwm, busy, cycle_done;
    logic [15:0] duty;
    logic        pwm3, busy3, cycle_done3;
    logic [15:0] duty3;

    int vecs;
    int errs;
    int n;

    pwm_breath_seq #(.PERIOD(16'd10), .STEP(16'd5), .HOLD_PERIODS(16'd2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pwm(pwm), .duty(duty), .busy(busy), .cycle_done(cycle_done)
    );

    pwm_breath_seq #(.PERIOD(16'd10), .STEP(16'd3), .HOLD_PERIODS(16'd2)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop(stop3),
        .pwm(pwm3), .duty(duty3), .busy(busy3), .cycle_done(cycle_done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected duty in cycle n of a free-running STEP=5 breath (80 clk long).
    function automatic int exp_duty5(input int c);
        case ((c / 10) % 8)
            1, 5:    return 5;
            2, 3, 4: return 10;
            default: return 0;
        endcase
    endfunction

    // Expected duty per period for STEP=3: up 0,3,6,9,10, hold, down 7,4,1,0.
    function automatic int exp_duty3(input int c);
        case (c / 10)
            1:       return 3;
            2:       return 6;
            3:       return 9;
            4, 5, 6: return 10;
            7:       return 7;
            8:       return 4;
            9:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start  = ~start;
            start3 = ~start3;
            tick();
            vecs++;
            if (pwm !== 1'b0 || duty !== 16'd0 || busy !== 1'b0 || cycle_done !== 1'b0) begin
                errs++;
                $display("FAIL reset_dut5 cyc%0d: pwm=%b duty=%0d busy=%b done=%b, need all 0",
                         i, pwm, duty, busy, cycle_done);
            end
            vecs++;
            if (pwm3 !== 1'b0 || duty3 !== 16'd0 || busy3 !== 1'b0 || cycle_done3 !== 1'b0) begin
                errs++;
                $display("FAIL reset_dut3 cyc%0d: pwm=%b duty=%0d busy=%b done=%b, need all 0",
                         i, pwm3, duty3, busy3, cycle_done3);
            end
        end
        start  = 1'b0;
        start3 = 1'b0;
        rst    = 1'b0;
        tick();
    endtask

    task automatic test_start_ramp();
        int highs;
        highs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        vecs++;
        if (busy !== 1'b1 || duty !== 16'd0) begin
            errs++;
            $display("FAIL start_accept: busy=%b duty=%0d, need busy=1 duty=0", busy, duty);
        end
        while (n < 29) begin
            tick();
            n++;
            if (n >= 10 && n < 20 && pwm === 1'b1) highs++;
            if (n == 10) begin
                vecs++;
                if (duty !== 16'd5) begin
                    errs++;
                    $display("FAIL ramp_pe1: duty=%0d need 5", duty);
                end
            end
            if (n == 20) begin
                vecs++;
                if (duty !== 16'd10) begin
                    errs++;
                    $display("FAIL ramp_pe2: duty=%0d need 10", duty);
                end
                vecs++;
                if (highs != 5) begin
                    errs++;
                    $display("FAIL pwm_half_duty: high clks=%0d need 5", highs);
                end
            end
        end
    endtask

    task automatic test_free_run();
        while (n < 165) begin
            tick();
            n++;
            vecs++;
            if (duty !== 16'(exp_duty5(n)) || pwm !== ((n % 10) < exp_duty5(n))
                || busy !== 1'b1 || cycle_done !== (n % 80 == 79)) begin
                errs++;
                $display("FAIL free_run n=%0d: duty=%0d pwm=%b busy=%b done=%b, need duty=%0d pwm=%b busy=1 done=%b",
                         n, duty, pwm, busy, cycle_done, exp_duty5(n),
                         (n % 10) < exp_duty5(n), n % 80 == 79);
            end
        end
    endtask

    task automatic test_ignore_start();
        start = 1'b1;
        tick();
        n++;
        start = 1'b0;
        while (n < 185) begin
            vecs++;
            if (duty !== 16'(exp_duty5(n)) || busy !== 1'b1 || cycle_done !== 1'b0) begin
                errs++;
                $display("FAIL ignore_start n=%0d: duty=%0d busy=%b done=%b, need duty=%0d busy=1 done=0",
                         n, duty, busy, cycle_done, exp_duty5(n));
            end
            tick();
            n++;
        end
    endtask

    task automatic test_stop_hold();
        logic exp_busy;
        int   exp_d;
        stop = 1'b1;
        tick();
        n++;
        stop = 1'b0;
        while (n < 260) begin
            exp_busy = (n < 240);
            exp_d    = exp_busy ? exp_duty5(n) : 0;
            vecs++;
            if (duty !== 16'(exp_d) || busy !== exp_busy || cycle_done !== (n == 239)
                || pwm !== ((n % 10) < exp_d)) begin
                errs++;
                $display("FAIL stop_hold n=%0d: duty=%0d busy=%b done=%b pwm=%b, need duty=%0d busy=%b done=%b",
                         n, duty, busy, cycle_done, pwm, exp_d, exp_busy, n == 239);
            end
            tick();
            n++;
        end
    endtask

    task automatic test_start_stop_same();
        int   pulses;
        logic exp_busy;
        int   exp_d;
        pulses = 0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n = 0;
        while (n < 100) begin
            exp_busy = (n < 80);
            exp_d    = exp_busy ? exp_duty5(n) : 0;
            if (cycle_done === 1'b1) pulses++;
            vecs++;
            if (duty !== 16'(exp_d) || busy !== exp_busy || cycle_done !== (n == 79)) begin
                errs++;
                $display("FAIL start_stop_same n=%0d: duty=%0d busy=%b done=%b, need duty=%0d busy=%b done=%b",
                         n, duty, busy, cycle_done, exp_d, exp_busy, n == 79);
            end
            tick();
            n++;
        end
        vecs++;
        if (pulses != 1) begin
            errs++;
            $display("FAIL one_breath_pulses: saw %0d cycle_done pulses, need 1", pulses);
        end
    endtask

    task automatic test_step3_reset();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (n < 81) begin
            vecs++;
            if (duty3 !== 16'(exp_duty3(n)) || busy3 !== 1'b1 || cycle_done3 !== 1'b0) begin
                errs++;
                $display("FAIL step3 n=%0d: duty=%0d busy=%b done=%b, need duty=%0d busy=1 done=0",
                         n, duty3, busy3, cycle_done3, exp_duty3(n));
            end
            tick();
            n++;
        end
        vecs++;
        if (pwm3 !== 1'b1 || duty3 !== 16'd4) begin
            errs++;
            $display("FAIL step3_pre_rst: pwm=%b duty=%0d, need pwm=1 duty=4", pwm3, duty3);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if (pwm3 !== 1'b0 || duty3 !== 16'd0 || busy3 !== 1'b0 || cycle_done3 !== 1'b0) begin
            errs++;
            $display("FAIL async_rst: pwm=%b duty=%0d busy=%b done=%b, need all 0",
                     pwm3, duty3, busy3, cycle_done3);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        vecs++;
        if (busy3 !== 1'b0 || duty3 !== 16'd0 || pwm3 !== 1'b0) begin
            errs++;
            $display("FAIL post_rst_idle: busy=%b duty=%0d pwm=%b, need 0 0 0", busy3, duty3, pwm3);
        end
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        n      = 0;
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        start3 = 1'b0;
        stop3  = 1'b0;
        test_reset();
        test_start_ramp();
        test_free_run();
        test_ignore_start();
        test_stop_hold();
        test_start_stop_same();
        test_step3_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
